// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment decoder: glyph table,
// logical all-on/all-off words and segment bit positions.
package seg7_pkg;

  // Bit positions inside the 8-bit segment word {dp, g, f, e, d, c, b, a}.
  typedef enum logic [2:0] {
    SEG_A  = 3'd0,
    SEG_B  = 3'd1,
    SEG_C  = 3'd2,
    SEG_D  = 3'd3,
    SEG_E  = 3'd4,
    SEG_F  = 3'd5,
    SEG_G  = 3'd6,
    SEG_DP = 3'd7
  } seg_bit_e;

  // Logical polarity: 1 = segment lit.
  localparam logic [7:0] SEG_ALL_ON_L  = 8'hFF;
  localparam logic [7:0] SEG_ALL_OFF_L = 8'h00;

  // Glyphs g..a, logical polarity. b and d are lowercase so they stay
  // distinguishable from 8 and 0.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational nibble-to-glyph lookup, logical polarity (1 = lit).
module hex_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] glyph
);

  // Every nibble value has a glyph, so no default case is needed.
  always_comb begin
    glyph = GLYPH_TABLE[hex];
  end

endmodule

// File: rtl/hex_seven_seg_decoder.sv
// Registered hex-to-seven-segment decoder with lamp test, blanking,
// decimal point control and selectable output polarity.
module hex_seven_seg_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] hex_in,
  input  logic       dp_in,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [7:0] seg_out
);

  // Drive value for "all segments off" in the configured polarity.
  localparam logic [7:0] SEG_OFF_DRIVE = ACTIVE_LOW ? ~SEG_ALL_OFF_L : SEG_ALL_OFF_L;

  logic [6:0] glyph;
  logic [7:0] seg_logical;
  logic [7:0] seg_drive;

  hex_glyph_rom u_rom (
    .hex   (hex_in),
    .glyph (glyph)
  );

  // Priority mux in logical polarity: lamp test beats blank beats decode.
  always_comb begin
    seg_logical = {1'b0, glyph};
    seg_logical[SEG_DP] = dp_in;
    if (lamp_test) begin
      seg_logical = SEG_ALL_ON_L;
    end else if (blank) begin
      seg_logical = SEG_ALL_OFF_L;
    end
  end

  // Polarity conversion to the physical drive level.
  always_comb begin
    seg_drive = ACTIVE_LOW ? ~seg_logical : seg_logical;
  end

  // Output register; reset blanks the display without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_OFF_DRIVE;
    end else if (en) begin
      seg_out <= seg_drive;
    end
  end

endmodule

// File: tb/tb_hex_seven_seg_decoder.sv
// Self-checking bench: two decoder instances (active-low and active-high)
// share the same stimulus; a scoreboard queue holds expected logical words.
module tb_hex_seven_seg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [3:0] hex_in = 4'h8;
  logic       dp_in = 1'b0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [7:0] seg_al;
  logic [7:0] seg_ah;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_reg = 8'h00;

  // Independent reference glyphs, g..a logical.
  logic [6:0] ref_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Published active-low codes with dp off, used to cross-check the sweep.
  logic [7:0] ref_al [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  hex_seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hex_in    (hex_in),
    .dp_in     (dp_in),
    .blank     (blank),
    .lamp_test (lamp_test),
    .seg_out   (seg_al)
  );

  hex_seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hex_in    (hex_in),
    .dp_in     (dp_in),
    .blank     (blank),
    .lamp_test (lamp_test),
    .seg_out   (seg_ah)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, predict, then compare
  // both instances just after the following rising edge.
  task automatic step(input string tag, input logic [3:0] h, input logic dp,
                      input logic bl, input logic lt, input logic e);
    logic [7:0] exp;
    @(negedge clk);
    hex_in = h; dp_in = dp; blank = bl; lamp_test = lt; en = e;
    if (e) begin
      if (lt)      model_reg = 8'hFF;
      else if (bl) model_reg = 8'h00;
      else         model_reg = {dp, ref_glyph[h]};
    end
    exp_q.push_back(model_reg);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 8'h00, 8'h01);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_al"}, seg_al, ~exp);
      check({tag, "_ah"}, seg_ah, exp);
    end
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between.
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_al", seg_al, 8'hFF);
    check("rst_async_ah", seg_ah, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_al", seg_al, 8'hFF);
    check("rst_hold_ah", seg_ah, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reg = 8'h00;
    step("rst_release", 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full sweep, also cross-checked against the published active-low codes.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_%0h", i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("sweep_tbl_%0h", i), seg_al, ref_al[i]);
    end

    // Decimal point.
    step("dp_0", 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("dp_0_abs", seg_al, 8'h40);
    step("dp_f", 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("dp_f_abs", seg_al, 8'h0E);

    // Priority.
    step("prio_blank", 4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
    check("prio_blank_abs", seg_al, 8'hFF);
    step("prio_lamp", 4'h5, 1'b1, 1'b1, 1'b1, 1'b1);
    check("prio_lamp_abs", seg_al, 8'h00);
    step("prio_lamp_only", 4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
    step("prio_none", 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("prio_none_abs", seg_al, 8'h92);

    // Hold while en=0, even with lamp test and blank toggling.
    step("hold_load", 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_load_abs", seg_al, 8'hB0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("hold_%0d", i), 4'h7, i[0], i[1], i[2], 1'b0);
      check($sformatf("hold_abs_%0d", i), seg_al, 8'hB0);
    end
    step("hold_release", 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_release_abs", seg_al, 8'hF8);

    // Active-high polarity.
    step("pol_ah", 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    check("pol_ah_abs", seg_ah, 8'hDB);

    // Reset mid-cycle overrides lamp test and enable.
    step("pre_rst_lamp", 4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_al", seg_al, 8'hFF);
    check("rst_mid_ah", seg_ah, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reg = 8'h00;
    step("post_rst", 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_abs", seg_al, 8'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
